// File: rtl/jk_ff.sv
// Parameterised bank of independent JK flip-flops.
// Synchronous active-high reset loads RESET_VALUE; all updates happen on the rising edge of clk.
module jk_ff #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

    // Characteristic equation: a clear bit sets on j, a set bit survives unless k.
    // j=k=1 therefore toggles, and j=k=0 holds.
    always_comb begin
        w_q_next = (j & ~r_q) | (~k & r_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_jk_ff.sv
// Self-checking bench for jk_ff: a WIDTH=1 instance driven from a vector table plus
// hand-written reset-timing sequences, and a WIDTH=4 instance for per-bit and random checks.
module tb_jk_ff;

  logic       clk;
  logic       rst1, j1, k1;
  logic       q1;
  logic       rst4;
  logic [3:0] j4, k4;
  logic [3:0] q4;

  int total;
  int bad;

  logic [3:0] exp_q[$];

  localparam logic [3:0] W4_RESET = 4'b0011;

  jk_ff u_dut1 (
    .j   (j1),
    .k   (k1),
    .clk (clk),
    .rst (rst1),
    .q   (q1)
  );

  jk_ff #(
    .WIDTH       (4),
    .RESET_VALUE (W4_RESET)
  ) u_dut4 (
    .j   (j4),
    .k   (k4),
    .clk (clk),
    .rst (rst4),
    .q   (q4)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic rst;
    logic j;
    logic k;
    logic exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // drive the 1-bit instance mid-period
  task automatic drive1(input logic r, input logic jj, input logic kk);
    @(negedge clk);
    rst1 = r;
    j1   = jj;
    k1   = kk;
  endtask

  task automatic drive4(input logic r, input logic [3:0] jj, input logic [3:0] kk);
    @(negedge clk);
    rst4 = r;
    j4   = jj;
    k4   = kk;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] jk_model(input logic [3:0] cur, input logic [3:0] jj,
                                          input logic [3:0] kk);
    logic [3:0] nxt;
    for (int b = 0; b < 4; b++) begin
      case ({jj[b], kk[b]})
        2'b00:   nxt[b] = cur[b];
        2'b01:   nxt[b] = 1'b0;
        2'b10:   nxt[b] = 1'b1;
        default: nxt[b] = ~cur[b];
      endcase
    end
    return nxt;
  endfunction

  initial begin
    logic [3:0] model_q;
    logic [3:0] rj, rk;
    logic [3:0] want;

    total = 0;
    bad   = 0;
    rst1  = 1'b1;
    j1    = 1'b0;
    k1    = 1'b0;
    rst4  = 1'b1;
    j4    = 4'b0000;
    k4    = 4'b0000;

    // reset override, truth table, toggle run, then set q=1 for the timing sequence
    vecs[0]  = '{rst: 1'b1, j: 1'b1, k: 1'b1, exp: 1'b0};
    vecs[1]  = '{rst: 1'b1, j: 1'b0, k: 1'b1, exp: 1'b0};
    vecs[2]  = '{rst: 1'b1, j: 1'b1, k: 1'b0, exp: 1'b0};
    vecs[3]  = '{rst: 1'b0, j: 1'b1, k: 1'b0, exp: 1'b1};
    vecs[4]  = '{rst: 1'b0, j: 1'b0, k: 1'b0, exp: 1'b1};
    vecs[5]  = '{rst: 1'b0, j: 1'b0, k: 1'b1, exp: 1'b0};
    vecs[6]  = '{rst: 1'b0, j: 1'b0, k: 1'b0, exp: 1'b0};
    vecs[7]  = '{rst: 1'b0, j: 1'b1, k: 1'b1, exp: 1'b1};
    vecs[8]  = '{rst: 1'b0, j: 1'b1, k: 1'b1, exp: 1'b0};
    vecs[9]  = '{rst: 1'b0, j: 1'b1, k: 1'b1, exp: 1'b1};
    vecs[10] = '{rst: 1'b0, j: 1'b1, k: 1'b1, exp: 1'b0};
    vecs[11] = '{rst: 1'b0, j: 1'b1, k: 1'b0, exp: 1'b1};

    for (int i = 0; i < 12; i++) begin
      drive1(vecs[i].rst, vecs[i].j, vecs[i].k);
      after_edge();
      check($sformatf("vec%0d", i), {3'b000, q1}, {3'b000, vecs[i].exp});
    end

    // rst raised mid-period must not touch q before the edge
    drive1(1'b1, 1'b0, 1'b0);
    #1;
    check("rst_mid_hold", {3'b000, q1}, 4'b0001);
    after_edge();
    check("rst_edge_clear", {3'b000, q1}, 4'b0000);
    // release with a set request: q stays 0 until the next edge, then 1
    drive1(1'b0, 1'b1, 1'b0);
    #1;
    check("rel_mid_hold", {3'b000, q1}, 4'b0000);
    after_edge();
    check("rel_edge_set", {3'b000, q1}, 4'b0001);
    // toggle request under reset is overridden
    drive1(1'b1, 1'b1, 1'b1);
    after_edge();
    check("rst_over_toggle", {3'b000, q1}, 4'b0000);

    // WIDTH=4: reset to its non-zero reset value, held for three edges
    for (int i = 0; i < 3; i++) begin
      drive4(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      after_edge();
      check($sformatf("w4_rst%0d", i), q4, W4_RESET);
    end

    // per-bit independence: set, clear, toggle and hold side by side
    drive4(1'b0, 4'b1010, 4'b0110);
    after_edge();
    check("w4_indep", q4, 4'b1001);

    // random regression against the bench model
    model_q = 4'b1001;
    for (int i = 0; i < 16; i++) begin
      rj = 4'($urandom_range(0, 15));
      rk = 4'($urandom_range(0, 15));
      model_q = jk_model(model_q, rj, rk);
      exp_q.push_back(model_q);
      drive4(1'b0, rj, rk);
      after_edge();
      want = exp_q.pop_front();
      check($sformatf("w4_rand%0d j=%b k=%b", i, rj, rk), q4, want);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_ff.md
JK_FF -- requirements
Module: jk_ff

Interface
REQ-001 Parameter: WIDTH, default 1, number of independent JK bit-cells; j, k and q are all WIDTH bits wide.
REQ-002 Parameter: RESET_VALUE, default all-zeros, value loaded into q on reset; WIDTH bits.
REQ-003 Port: clk  input  1  single clock; all state changes occur on its rising edge only.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: j  input  WIDTH  per-bit set request.
REQ-006 Port: k  input  WIDTH  per-bit clear request.
REQ-007 Port: q  output  WIDTH  registered flip-flop state.
REQ-008 Positional port order SHALL be (j, k, clk, rst, q), so that instance "jk_ff u (j, k, clk, rst, q)" connects correctly.
REQ-009 The design SHALL use one clock and synchronous, active-high reset only; there SHALL be no asynchronous set/clear and no other clock.

Function
REQ-010 q SHALL be a register updated only at the rising edge of clk; between edges q SHALL hold its value regardless of j, k or rst activity.
REQ-011 At a rising edge with rst=0, each bit i SHALL update from its own j[i], k[i] and current q[i]:
  - j=0, k=0: hold, q[i] unchanged
  - j=0, k=1: clear, q[i]=0
  - j=1, k=0: set, q[i]=1
  - j=1, k=1: toggle, q[i]=~q[i]
REQ-012 Latency SHALL be exactly one clock edge: the new q is visible immediately after the rising edge that samples j/k; no combinational path from j, k or rst to q.
REQ-013 Bits SHALL be fully independent; one bit's j/k SHALL NOT affect any other bit.
REQ-014 Toggle with j=k=1 held over N consecutive edges SHALL make q alternate every edge: q after N edges = initial q XOR (N mod 2).
REQ-015 j, k and rst SHALL be sampled with the values present immediately before the rising edge; changes coincident with or after the edge take effect on the following edge.
REQ-016 If j or k is X/Z at a sampling edge with rst=0, the affected q bit MAY become X; any valid reset or a defined j/k combination SHALL restore a known value.

Reset
REQ-017 At a rising edge with rst=1, q SHALL be loaded with RESET_VALUE (0 for the default), overriding j and k in every combination, including j=k=1.
REQ-018 Assertion of rst between edges SHALL NOT change q until the next rising edge.
REQ-019 Deassertion of rst SHALL resume JK operation on the first rising edge at which rst=0 is sampled, using that edge's j/k.
REQ-020 Before the first rising edge with rst=1 or a defined set/clear, q MAY be unknown; no power-on initial value is required.
REQ-021 rst held high over multiple edges SHALL keep q at RESET_VALUE throughout.

Verification
REQ-022 Each scenario SHALL change inputs mid-period, away from rising edges.
REQ-023 Reset override: rst=1, j=1, k=1, one edge -> q=0; hold rst=1 for two more edges with j/k random -> q stays 0.
REQ-024 Truth table from q=0 with rst=0: j=1,k=0 edge -> q=1; j=0,k=0 edge -> q=1; j=0,k=1 edge -> q=0; j=0,k=0 edge -> q=0.
REQ-025 Toggle: from q=0, rst=0, j=k=1 for 4 edges -> q sequence 1,0,1,0.
REQ-026 Sync-reset timing: q=1, raise rst mid-period -> q stays 1 until the next rising edge, then q=0; drop rst mid-period with j=1,k=0 -> q=1 after the following edge.
REQ-027 Random regression: at least 3 reset edges, then 12 or more edges of random j/k with rst=0, checked edge-by-edge against REQ-011; WIDTH=4 instance checks per-bit independence (j=4'b1010, k=4'b0110 from q=4'b0011 -> q=4'b1001).
